br_stack: RTL
=============

Name: br_stack

Overview:
- Branch checkpoint stack for the R10K rename stage.
- On each branch dispatch it captures the map-table snapshot (32 entries of {RDY, preg}) and the free-list head pointer.
- Keeps stored ready bits current from CDB broadcasts.
- On a ROB-reported misprediction, drives the oldest checkpoint back to the map table and free list for single-cycle recovery.
- Branches resolve in program order at the ROB, so storage is a circular FIFO of checkpoints.

Parameters:
- DEPTH, 4, number of checkpoint slots (power of 2).
- FL_PTR_W, 5, width of the free-list head pointer snapshot.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- push_en_i  input  1  branch dispatched this cycle; capture a checkpoint
- bak_data_i  input  [31:0][6:0]  map-table snapshot; bit [6] = RDY, [5:0] = preg
- bak_fl_head_i  input  FL_PTR_W  free-list head at the branch
- cdb_set_rdy_bit_preg_i  input  6  preg broadcast on CDB
- cdb_set_rdy_bit_en_i  input  1  CDB broadcast valid
- branch_state_i  input  `BR_STATE_W  `BR_NONE / `BR_PR_CORRECT / `BR_PR_WRONG for the oldest branch
- rc_mt_all_data_o  output  [31:0][6:0]  recovery map table (oldest checkpoint, CDB-bypassed)
- rc_fl_head_o  output  FL_PTR_W  recovery free-list head
- full_o  output  1  all DEPTH slots valid; dispatch must stall branches
- empty_o  output  1  no valid checkpoint
- count_o  output  $clog2(DEPTH)+1  number of valid checkpoints

Behaviour:
- Reset (async, rst==0):
  - head=0, tail=0, count=0; all valid bits 0.
  - empty_o=1, full_o=0, count_o=0.
  - Outputs present slot 0 contents, which are zeroed.
- Storage per slot: mt[32][7], fl_head, valid. head = oldest, tail = next free; pointers wrap modulo DEPTH.
- Push (push_en_i && !full_o && branch_state_i!=`BR_PR_WRONG):
  - Slot[tail] <= bak_data_i with CDB bypass: any entry whose preg == cdb preg while CDB is valid stores RDY=1.
  - fl_head stored; tail++, count++.
- Push while full: ignored, no state change (upstream is required to stall).
- `BR_PR_CORRECT with !empty: slot[head].valid<=0, head++, count--.
  - Push in the same cycle is also performed; count unchanged.
  - Push + correct while full: the push is accepted, since a slot is freed the same cycle.
- `BR_PR_WRONG with !empty:
  - All slots invalidated; head<=0, tail<=0, count<=0.
  - A same-cycle push is dropped, because the branch is on the wrong path.
- `BR_PR_CORRECT/WRONG while empty: ignored.
- CDB update: every cycle with cdb_set_rdy_bit_en_i, every valid slot and every entry whose preg matches gets RDY<=1. Multiple matches are all set; there is no first-match break.
- Recovery outputs are combinational from slot[head]:
  - rc_mt_all_data_o[i] = slot[head].mt[i], with RDY forced to 1 if that preg matches the CDB this cycle.
  - This bypass prevents a ready bit being lost on the recovery cycle.
  - rc_fl_head_o = slot[head].fl_head.
  - Outputs are only meaningful when !empty_o. The consumer registers them (0-cycle latency here, 1 cycle to map-table state).
- full_o = (count==DEPTH); empty_o = (count==0); both derived from the registered count.
- Reset mid-operation: immediate clear regardless of clock; pending push is lost.

Decomposition:
- Shared package (sys_defs): `BR_STATE_W, `BR_NONE, `BR_PR_CORRECT, `BR_PR_WRONG, `SD, and the packed type for a map entry {rdy, preg[5:0]}.
- Sub-module br_ckpt_entry: one slot that holds mt/fl_head, applies CDB ready-bit updates, and supports load/clear. br_stack instantiates DEPTH of them plus pointer/count logic.

Test Plan:
- Reset, then push one checkpoint with entry 3 = {0,6'd40}, fl_head=7 -> count_o=1, empty_o=0; rc_mt_all_data_o[3]=7'h28, rc_fl_head_o=7.
- Push 4 in consecutive cycles, then a 5th -> full_o=1 after 4th; the 5th is ignored, count_o stays 4. Then `BR_PR_CORRECT + push same cycle -> count_o=4, head advances, rc_fl_head_o = 2nd checkpoint value.
- 2 checkpoints holding preg 40 unready; CDB preg 40 for one cycle -> both slots' entry RDY=1; `BR_PR_CORRECT pops the first, and the second shows RDY=1.
- `BR_PR_WRONG on the same cycle as CDB preg 40 (entry unready in head) -> rc_mt_all_data_o shows RDY=1 that cycle; next cycle count_o=0, empty_o=1.
- `BR_PR_WRONG with push_en_i=1, 3 valid -> all cleared, push dropped, count_o=0. Wrap: 6 push/pop pairs -> pointers wrap and data stays correct.
- Assert rst=0 asynchronously mid-cycle with 3 valid -> count_o=0 and empty_o=1 before the next clock edge; `BR_PR_CORRECT while empty -> no change.

Source files
------------

// File: rtl/br_stack_pkg.sv
// Shared rename-stage definitions for the branch checkpoint stack.
// Defines the branch-resolution states, the map-table entry layout
// {rdy, preg}, and a helper that applies a CDB ready-bit broadcast to a
// full map-table image.
package br_stack_pkg;

  localparam int unsigned NUM_ARCH   = 32;
  localparam int unsigned PREG_W     = 6;
  localparam int unsigned BR_STATE_W = 2;

  typedef enum logic [BR_STATE_W-1:0] {
    BR_NONE       = 2'd0,
    BR_PR_CORRECT = 2'd1,
    BR_PR_WRONG   = 2'd2
  } br_state_e;

  typedef struct packed {
    logic              rdy;
    logic [PREG_W-1:0] preg;
  } map_entry_t;

  typedef map_entry_t [NUM_ARCH-1:0] map_table_t;

  // Set RDY on every entry whose preg matches a valid CDB broadcast.
  // All matches are updated; there is no first-match break.
  function automatic map_table_t cdb_bypass(input map_table_t mt,
                                            input logic en,
                                            input logic [PREG_W-1:0] preg);
    map_table_t r;
    r = mt;
    for (int i = 0; i < int'(NUM_ARCH); i++) begin
      if (en && (mt[i].preg == preg)) r[i].rdy = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/br_ckpt_entry.sv
// One branch checkpoint slot: holds a map-table snapshot and free-list head.
// Ports: clk, rst (async active-low), load (capture load_mt/load_fl_head),
// clear (invalidate), cdb_en/cdb_preg (ready-bit broadcast),
// mt/fl_head (stored contents).
// Load wins over clear so a slot popped and refilled in the same cycle
// (push + correct while full) keeps the new checkpoint.
module br_ckpt_entry
  import br_stack_pkg::*;
#(
  parameter int unsigned FL_PTR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clear,
  input  map_table_t          load_mt,
  input  logic [FL_PTR_W-1:0] load_fl_head,
  input  logic                cdb_en,
  input  logic [PREG_W-1:0]   cdb_preg,
  output map_table_t          mt,
  output logic [FL_PTR_W-1:0] fl_head
);

  logic valid;

  // Slot storage; CDB updates are applied both to incoming and held data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      mt      <= '0;
      fl_head <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      mt      <= cdb_bypass(load_mt, cdb_en, cdb_preg);
      fl_head <= load_fl_head;
    end else if (clear) begin
      valid   <= 1'b0;
    end else if (valid) begin
      mt      <= cdb_bypass(mt, cdb_en, cdb_preg);
    end
  end

endmodule

// File: rtl/br_stack.sv
// Branch checkpoint FIFO for R10K-style rename recovery.
// Ports: clk, rst (async active-low); push_en_i/bak_data_i/bak_fl_head_i
// capture a checkpoint at branch dispatch; cdb_set_rdy_bit_* keep stored
// ready bits current; branch_state_i pops (correct) or flushes (wrong).
// rc_mt_all_data_o/rc_fl_head_o present the oldest checkpoint with the
// current CDB broadcast bypassed in; full_o/empty_o/count_o give occupancy.
module br_stack
  import br_stack_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned FL_PTR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_en_i,
  input  map_table_t                 bak_data_i,
  input  logic [FL_PTR_W-1:0]        bak_fl_head_i,
  input  logic [PREG_W-1:0]          cdb_set_rdy_bit_preg_i,
  input  logic                       cdb_set_rdy_bit_en_i,
  input  br_state_e                  branch_state_i,
  output map_table_t                 rc_mt_all_data_o,
  output logic [FL_PTR_W-1:0]        rc_fl_head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             do_push, do_pop, do_flush;

  map_table_t          slot_mt [DEPTH];
  logic [FL_PTR_W-1:0] slot_fl [DEPTH];

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;

  // Resolution/push qualification and next pointer/count values.
  always_comb begin
    do_flush  = 1'b0;
    do_pop    = 1'b0;
    do_push   = 1'b0;
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;

    do_flush = (branch_state_i == BR_PR_WRONG)   && !empty_o;
    do_pop   = (branch_state_i == BR_PR_CORRECT) && !empty_o;
    // A pop frees a slot this cycle, so a push while full is still taken.
    do_push  = push_en_i && (branch_state_i != BR_PR_WRONG) && (!full_o || do_pop);

    if (do_flush) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
    end else begin
      if (do_pop)  head_nxt = head + PTR_W'(1);
      if (do_push) tail_nxt = tail + PTR_W'(1);
      count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_slot
    br_ckpt_entry #(
      .FL_PTR_W(FL_PTR_W)
    ) u_entry (
      .clk         (clk),
      .rst         (rst),
      .load        (do_push && (tail == PTR_W'(g))),
      .clear       (do_flush || (do_pop && (head == PTR_W'(g)))),
      .load_mt     (bak_data_i),
      .load_fl_head(bak_fl_head_i),
      .cdb_en      (cdb_set_rdy_bit_en_i),
      .cdb_preg    (cdb_set_rdy_bit_preg_i),
      .mt          (slot_mt[g]),
      .fl_head     (slot_fl[g])
    );
  end

  // Recovery view of the oldest checkpoint; bypass keeps a same-cycle
  // CDB wakeup from being lost on the recovery cycle.
  assign rc_mt_all_data_o = cdb_bypass(slot_mt[head], cdb_set_rdy_bit_en_i,
                                       cdb_set_rdy_bit_preg_i);
  assign rc_fl_head_o     = slot_fl[head];

endmodule
